// File: rtl/action_capture_pkg.sv
// Shared game constants: action codes, widths and the pending-slot state type.
// The action-side converter and the board logic use the same definitions.
package action_capture_pkg;

  localparam int ACT_W = 3;
  localparam int BTN_N = 6;

  localparam logic [ACT_W-1:0] ACT_NONE = 3'd0;
  localparam logic [ACT_W-1:0] ACT_1    = 3'd1;
  localparam logic [ACT_W-1:0] ACT_2    = 3'd2;
  localparam logic [ACT_W-1:0] ACT_3    = 3'd3;
  localparam logic [ACT_W-1:0] ACT_4    = 3'd4;
  localparam logic [ACT_W-1:0] ACT_5    = 3'd5;
  localparam logic [ACT_W-1:0] ACT_6    = 3'd6;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } pend_state_t;

  // Lowest set bit wins; code is bit index + 1, ACT_NONE when no bit is set.
  function automatic logic [ACT_W-1:0] encode_lowest(input logic [BTN_N-1:0] ev);
    logic [ACT_W-1:0] code;
    code = ACT_NONE;
    for (int i = BTN_N - 1; i >= 0; i--) begin
      if (ev[i]) code = ACT_W'(i + 1);
    end
    return code;
  endfunction

  function automatic logic multi_hot(input logic [BTN_N-1:0] ev);
    return (ev & (ev - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/action_capture_btn_debounce.sv
// One button: two-flop synchroniser, debounce counter and debounced rising-edge strobe.
// The press strobe fires in the same cycle the debounced level is about to flip high.
module btn_debounce #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             deb_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             differ;
  logic             expire;

  assign differ = sync_reg[1] != deb_reg;
  assign expire = differ && (cnt_reg == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      deb_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], btn};
      if (!differ) begin
        cnt_reg <= '0;
      end else if (expire) begin
        // Counter clears on the flip, so it never passes CNT_MAX.
        deb_reg <= ~deb_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press = expire && !deb_reg;

endmodule

// File: rtl/action_capture.sv
// Per-player action producer: debounces six buttons, keeps one pending action
// and publishes it as a stable code for the game step following each tick.
module action_capture
  import action_capture_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [BTN_N-1:0] btn,
  output logic [ACT_W-1:0] act,
  output logic             pend,
  output logic             drop
);

  logic [BTN_N-1:0] press_ev;

  generate
    for (genvar gi = 0; gi < BTN_N; gi++) begin : g_btn
      btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
      ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn[gi]),
        .press(press_ev[gi])
      );
    end
  endgenerate

  pend_state_t      state_reg, state_next;
  logic [ACT_W-1:0] code_reg, code_next;
  logic [ACT_W-1:0] act_reg, act_next;
  logic             drop_reg, drop_next;
  logic             any_press;
  logic [ACT_W-1:0] press_code;

  assign any_press  = |press_ev;
  assign press_code = encode_lowest(press_ev);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      code_reg  <= ACT_NONE;
      act_reg   <= ACT_NONE;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      code_reg  <= code_next;
      act_reg   <= act_next;
      drop_reg  <= drop_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    act_next   = act_reg;
    // Losers of a same-cycle priority resolution are always discarded.
    drop_next  = multi_hot(press_ev);

    if (tick) begin
      act_next = (state_reg == ST_FULL) ? code_reg : ACT_NONE;
      if (any_press) begin
        state_next = ST_FULL;
        code_next  = press_code;
      end else begin
        state_next = ST_EMPTY;
        code_next  = ACT_NONE;
      end
    end else if (any_press) begin
      if (state_reg == ST_EMPTY) begin
        state_next = ST_FULL;
        code_next  = press_code;
      end else begin
        // First press wins while an action is waiting.
        drop_next = 1'b1;
      end
    end
  end

  assign act  = act_reg;
  assign pend = (state_reg == ST_FULL);
  assign drop = drop_reg;

endmodule
